// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage byte-serial access sequencer.
package mem_pkg;

  localparam int unsigned ADDRESSL = 32;
  localparam int unsigned WORD     = 32;
  localparam int unsigned MEMW     = 8;
  localparam int unsigned LANES    = WORD / MEMW;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  function automatic logic [2:0] beat_count(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'(LANES);
    endcase
  endfunction

  function automatic logic size_legal(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lsb[0];
      SZ_WORD: return lsb == 2'b00;
      SZ_ILL:  return 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  // Left-justify the sized store data so lane 0 (MSB) is the first byte sent.
  function automatic logic [WORD-1:0] lane_align(input logic [WORD-1:0] wdata,
                                                 input logic [1:0]      size);
    return wdata << (MEMW * (LANES - 32'(beat_count(size))));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and byte-wide data memory signals of the MEM stage.
interface mem_access_unit_if;
  import mem_pkg::*;

  logic                req_valid;
  logic                req_read;
  logic                req_write;
  logic [1:0]          req_size;
  logic                req_signed;
  logic [ADDRESSL-1:0] req_addr;
  logic [WORD-1:0]     req_wdata;

  logic                stall;
  logic                resp_valid;
  logic [WORD-1:0]     resp_rdata;
  logic                err;

  logic [ADDRESSL-1:0] mem_address;
  logic [MEMW-1:0]     mem_write_data;
  logic                mem_read;
  logic                mem_write;
  logic [MEMW-1:0]     mem_read_data;

  modport master (
    output req_valid, req_read, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_read_data,
    input  stall, resp_valid, resp_rdata, err,
    input  mem_address, mem_write_data, mem_read, mem_write
  );

  modport slave (
    input  req_valid, req_read, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_read_data,
    output stall, resp_valid, resp_rdata, err,
    output mem_address, mem_write_data, mem_read, mem_write
  );

endinterface

// File: rtl/mem_load_extend.sv
// Sign/zero extension of the right-justified load assembly register by access size.
module mem_load_extend
  import mem_pkg::*;
(
  input  logic [WORD-1:0] asm_data,
  input  logic [1:0]      size,
  input  logic            is_signed,
  output logic [WORD-1:0] rdata
);

  always_comb begin
    rdata = asm_data;
    unique case (size)
      SZ_BYTE: rdata = {{(WORD - 8){is_signed & asm_data[7]}}, asm_data[7:0]};
      SZ_HALF: rdata = {{(WORD - 16){is_signed & asm_data[15]}}, asm_data[15:0]};
      default: rdata = asm_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage sequencer: splits lb/lh/lw/sb/sh/sw into 1, 2 or 4 big-endian byte beats.
module mem_access_unit
  import mem_pkg::*;
(
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  state_e              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic                write_q, write_d;
  logic [ADDRESSL-1:0] base_q, base_d;
  logic [WORD-1:0]     wdata_q, wdata_d;
  logic [WORD-1:0]     asm_q, asm_d;
  logic [WORD-1:0]     rdata_q, rdata_d;
  logic [ADDRESSL-1:0] mem_address_q, mem_address_d;
  logic [MEMW-1:0]     mem_wdata_q, mem_wdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;

  logic                dir_ok, both_dir, legal, accept, reject, last_beat;
  logic [WORD-1:0]     lanes, ext_rdata;

  assign dir_ok    = bus.req_read ^ bus.req_write;
  assign both_dir  = bus.req_read & bus.req_write;
  assign legal     = size_legal(bus.req_size, bus.req_addr[1:0]);
  assign accept    = (state_q == StIdle) & bus.req_valid & dir_ok & legal;
  assign reject    = (state_q == StIdle) & bus.req_valid & (both_dir | (dir_ok & ~legal));
  assign last_beat = beat_q == 2'(beat_count(size_q) - 3'd1);
  assign lanes     = lane_align(bus.req_wdata, bus.req_size);

  mem_load_extend u_extend (
    .asm_data  (asm_q),
    .size      (size_q),
    .is_signed (signed_q),
    .rdata     (ext_rdata)
  );

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    size_d        = size_q;
    signed_d      = signed_q;
    write_d       = write_q;
    base_d        = base_q;
    wdata_d       = wdata_q;
    asm_d         = asm_q;
    rdata_d       = rdata_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d       = StAccess;
          beat_d        = 2'd0;
          size_d        = bus.req_size;
          signed_d      = bus.req_signed;
          write_d       = bus.req_write;
          base_d        = bus.req_addr;
          asm_d         = '0;
          // Beat 0 is staged here so memory only ever sees registered controls.
          mem_address_d = bus.req_addr;
          mem_wdata_d   = lanes[WORD-1 -: MEMW];
          wdata_d       = lanes << MEMW;
          mem_read_d    = bus.req_read;
          mem_write_d   = bus.req_write;
        end
      end
      StAccess: begin
        if (!write_q) begin
          asm_d = {asm_q[WORD-MEMW-1:0], bus.mem_read_data};
        end
        if (last_beat) begin
          state_d     = StDone;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end else begin
          beat_d        = beat_q + 2'd1;
          mem_address_d = base_q + ADDRESSL'(beat_d);
          mem_wdata_d   = wdata_q[WORD-1 -: MEMW];
          wdata_d       = wdata_q << MEMW;
        end
      end
      StDone: begin
        state_d = StIdle;
        rdata_d = ext_rdata;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      beat_q        <= '0;
      size_q        <= '0;
      signed_q      <= 1'b0;
      write_q       <= 1'b0;
      base_q        <= '0;
      wdata_q       <= '0;
      asm_q         <= '0;
      rdata_q       <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      write_q       <= write_d;
      base_q        <= base_d;
      wdata_q       <= wdata_d;
      asm_q         <= asm_d;
      rdata_q       <= rdata_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
    end
  end

  // Strobes are masked during reset so an aborted store stops before its next byte.
  assign bus.stall          = ~rst & (accept | (state_q == StAccess));
  assign bus.err            = ~rst & reject;
  assign bus.resp_valid     = ~rst & (state_q == StDone);
  assign bus.resp_rdata     = rst ? '0 : ((state_q == StDone) ? ext_rdata : rdata_q);
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.mem_read       = ~rst & mem_read_q;
  assign bus.mem_write      = ~rst & mem_write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a byte-wide memory model and response scoreboard.
module tb_mem_access_unit;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          beats;
  } vec_t;

  typedef struct {
    logic        is_err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic pl_en = 1'b0;
  logic [9:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  logic [7:0] mem [0:1023];
  int n_checks = 0;
  int n_fail = 0;
  int mem_acc = 0;
  exp_t sb_q[$];

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_read_data = mem[bus.mem_address[9:0]];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (bus.mem_write) begin
      mem[bus.mem_address[9:0]] <= bus.mem_write_data;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
  end

  task automatic check(input logic [31:0] act, input logic [31:0] exp, input string name);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_read || bus.mem_write) mem_acc++;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (bus.resp_valid || bus.err)) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=%b err=%b, expected none", bus.resp_valid,
                 bus.err);
      end else begin
        e = sb_q.pop_front();
        check({31'b0, bus.err}, {31'b0, e.is_err}, "resp_kind_err");
        check({31'b0, bus.resp_valid}, {31'b0, ~e.is_err}, "resp_kind_valid");
        if (!e.is_err) check(bus.resp_rdata, e.rdata, "resp_rdata");
      end
    end
  end

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    bus.req_valid  = 1'b1;
    bus.req_read   = v.rd;
    bus.req_write  = v.wr;
    bus.req_size   = v.size;
    bus.req_signed = v.sgn;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
  endtask

  task automatic wait_done(output int lat, output int stalls, output bit ok);
    lat = 0;
    stalls = 0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.stall) stalls++;
      if (bus.resp_valid || bus.err) ok = 1'b1;
      else lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat, stalls, acc0, exp_cyc;
    bit ok;
    exp_cyc = v.exp_err ? 0 : v.beats + 1;
    @(posedge clk); #1;
    drive(v);
    acc0 = mem_acc;
    sb_q.push_back('{is_err: v.exp_err, rdata: v.exp_rdata});
    wait_done(lat, stalls, ok);
    check({31'b0, ok}, 32'd1, {name, "_completed"});
    check(32'(stalls), 32'(exp_cyc), {name, "_stall_cycles"});
    check(32'(lat), 32'(exp_cyc), {name, "_latency"});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check(32'(mem_acc - acc0), 32'(v.beats), {name, "_mem_beats"});
    check({30'b0, bus.resp_valid, bus.err}, 32'd0, {name, "_pulse_one_cycle"});
    if (!v.exp_err) check(bus.resp_rdata, v.exp_rdata, {name, "_rdata_held"});
  endtask

  vec_t vecs[$];
  vec_t sw0;

  initial begin
    int lat, stalls, acc0;
    bit ok;

    bus.req_valid  = 1'b0;
    bus.req_read   = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check({28'b0, bus.stall, bus.resp_valid, bus.err, bus.mem_read}, 32'd0, "reset_flags");
    check({31'b0, bus.mem_write}, 32'd0, "reset_mem_write");
    check(bus.resp_rdata, 32'd0, "reset_resp_rdata");
    check(bus.mem_address, 32'd0, "reset_mem_address");
    check({24'b0, bus.mem_write_data}, 32'd0, "reset_mem_write_data");

    // Word store: four beats, MSB first.
    sw0 = '{rd: 1'b0, wr: 1'b1, size: 2'b10, sgn: 1'b0, addr: 32'h100, wdata: 32'h11223344,
            exp_err: 1'b0, exp_rdata: 32'h0, beats: 4};
    run_vec(sw0, "sw_100");
    check({mem[10'h100], mem[10'h101], mem[10'h102], mem[10'h103]}, 32'h11223344, "sw_100_bytes");

    preload(10'h100, 8'hF0);
    preload(10'h101, 8'h0F);
    preload(10'h102, 8'hAA);
    preload(10'h103, 8'h55);

    vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'hF00FAA55, 4});
    vecs.push_back('{1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 1'b0, 32'hFFFFF00F, 2});
    vecs.push_back('{1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b0, 32'h0000AA55, 2});
    vecs.push_back('{1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1'b0, 32'hFFFFAA55, 2});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 1'b0, 32'hFFFFFFAA, 1});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 1'b0, 32'h000000AA, 1});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 1'b0, 32'h0000000F, 1});
    vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b1, 32'h0, 0});
    vecs.push_back('{1'b1, 1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 1'b1, 32'h0, 0});
    vecs.push_back('{1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 0});
    vecs.push_back('{1'b0, 1'b1, 2'b01, 1'b0, 32'h103, 32'h0, 1'b1, 32'h0, 0});
    vecs.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 0});
    vecs.push_back('{1'b0, 1'b1, 2'b01, 1'b0, 32'h300, 32'h1234ABCD, 1'b0, 32'h0, 2});
    vecs.push_back('{1'b0, 1'b1, 2'b00, 1'b0, 32'h303, 32'h00000077, 1'b0, 32'h0, 1});
    vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 32'hABCD0077, 4});

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end
    check({mem[10'h100], mem[10'h101], mem[10'h102], mem[10'h103]}, 32'hF00FAA55,
          "illegal_store_no_write");

    // Reset while the third byte of a word store is on the bus.
    preload(10'h200, 8'h01);
    preload(10'h201, 8'h02);
    preload(10'h202, 8'h03);
    preload(10'h203, 8'h04);
    @(posedge clk); #1;
    drive('{1'b0, 1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF, 1'b0, 32'h0, 4});
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check({31'b0, bus.stall}, 32'd0, "rst_abort_idle");
    check({mem[10'h200], mem[10'h201], mem[10'h202], mem[10'h203]}, 32'hDEAD0304,
          "rst_abort_bytes");

    // Back-to-back store then load with req_valid held through each response.
    acc0 = mem_acc;
    @(posedge clk); #1;
    drive('{1'b0, 1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFEF00D, 1'b0, 32'h0, 4});
    sb_q.push_back('{is_err: 1'b0, rdata: 32'h0});
    wait_done(lat, stalls, ok);
    check({31'b0, ok}, 32'd1, "b2b_sw_completed");
    check(32'(stalls), 32'd5, "b2b_sw_stalls");
    @(posedge clk); #1;
    bus.req_read  = 1'b1;
    bus.req_write = 1'b0;
    sb_q.push_back('{is_err: 1'b0, rdata: 32'hCAFEF00D});
    wait_done(lat, stalls, ok);
    check({31'b0, ok}, 32'd1, "b2b_lw_completed");
    check(32'(stalls), 32'd5, "b2b_lw_stalls");
    check(32'(lat), 32'd5, "b2b_lw_latency");
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check(32'(mem_acc - acc0), 32'd8, "b2b_mem_beats");
    check(bus.resp_rdata, 32'hCAFEF00D, "b2b_rdata_held");

    check(32'(sb_q.size()), 32'd0, "scoreboard_drained");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage access sequencer sitting directly upstream of the byte-wide data memory. It is fed by the EX/MEM pipeline register and feeds the MEM/WB register.
- Converts 32-bit MIPS lb/lbu/lh/lhu/lw/sb/sh/sw requests into 1, 2 or 4 sequential byte accesses on the memory's address/writeData/readData/memRead/memWrite interface.
- Assembles and extends load data, and stalls the pipeline while beats are in flight.
- Byte order is big-endian: byte at the base address maps to bits [31:24] of a word.

Parameters:
- ADDRESSL, 32, address width (matches data memory)
- WORD, 32, pipeline data width
- MEMW, 8, data memory word width; WORD/MEMW = 4 lanes, fixed

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  EX/MEM holds a memory instruction
- req_read  in  1  load
- req_write  in  1  store
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend loads (lb/lh)
- req_addr  in  ADDRESSL  effective address
- req_wdata  in  WORD  store data (rt)
- stall  out  1  hold IF..EX/MEM this cycle
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  WORD  extended load data (0 for stores)
- err  out  1  one-cycle pulse: misaligned/illegal request, no access made
- mem_address  out  ADDRESSL  to data memory address
- mem_write_data  out  MEMW  to data memory writeData
- mem_read  out  1  to memRead
- mem_write  out  1  to memWrite
- mem_read_data  in  MEMW  from readData (combinational in memory)

Behaviour:
- Reset values:
  - FSM state IDLE, beat = 0, assembly register = 0.
  - Outputs stall, resp_valid, resp_rdata, err, mem_read, mem_write, mem_address and mem_write_data are all 0.
- Reset mid-ACCESS aborts the transaction: no resp_valid is produced, and bytes already written stay written.
- FSM states: IDLE, ACCESS, DONE.
- IDLE accept condition: req_valid & (req_read ^ req_write).
- Request legality:
  - Illegal when req_size = 11, half at an odd address, or word with addr[1:0] != 0.
  - Illegal requests pulse err for one cycle and stay in IDLE, with stall = 0 and no memory access.
  - req_read & req_write both set also pulses err.
- Legal accept:
  - Latch addr, size, signed, direction, and wdata pre-shifted into MSB-first lanes.
  - N = 1/2/4 beats. Set beat = 0 and go to ACCESS.
- ACCESS, beat k:
  - mem_address = base + k.
  - Store: mem_write = 1 and mem_write_data = latched lane k, where lane 0 is the most significant byte of the sized data.
  - Load: mem_read = 1, and mem_read_data is captured into the assembly register at the clock edge.
  - If k = N-1, go to DONE; otherwise beat increments.
- All mem_* outputs are driven from registers only. There is no combinational path from req_* to mem_*, so the level-sensitive memWrite sees a stable address.
- DONE:
  - resp_valid = 1.
  - resp_rdata is extended as follows: byte is sign- or zero-extended from bits [7:0], half from bits [15:0], word is passed through.
  - Always returns to IDLE; no acceptance in DONE, because the same instruction is still in EX/MEM.
- Stall and latency:
  - stall = (IDLE & legal accept) | ACCESS; stall = 0 in DONE so the pipeline advances on that edge.
  - Occupancy for an N-beat request accepted at cycle T: ACCESS spans T+1..T+N, resp_valid is at T+N+1, and the next request can be accepted at T+N+2.
- Address arithmetic is modulo 2^ADDRESSL; base + k never crosses alignment, so no carry beyond bit 1.
- resp_rdata is held until the next DONE; it is 0 after stores.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD
  - FSM state enum
  - beat-count function size -> N
  - LANES = WORD/MEMW
- One natural sub-module, mem_load_extend: combinational assembly-register -> resp_rdata extension by size/signed. It is unit-testable alone.

Test Plan:
- sw 0x11223344 to addr 0x100 -> 4 ACCESS cycles write 0x11,0x22,0x33,0x44 at 0x100..0x103; stall high for 5 cycles, resp_valid at cycle 6, resp_rdata = 0.
- Memory preloaded 0x100..0x103 = 0xF0,0x0F,0xAA,0x55; lw 0x100 -> resp_rdata = 0xF00FAA55. lh signed 0x100 -> 0xFFFFF00F. lhu 0x102 -> 0x0000AA55.
- lb signed 0x102 (0xAA) -> 0xFFFFFFAA; lbu -> 0x000000AA; 1 ACCESS cycle, resp_valid 2 cycles after accept.
- lw 0x102 and lh 0x101 -> err pulse, stall 0, mem_read / mem_write never asserted; req_size = 11 -> same.
- rst asserted during beat 2 of sw 0xDEADBEEF at 0x200 -> FSM to IDLE, no resp_valid; 0x200/0x201 hold 0xDE/0xAD, 0x202/0x203 unchanged.
- Back-to-back: sw then lw to the same address with req_valid held high through DONE -> exactly one transaction each, and the load returns the stored word.
